// File: rtl/dlx_pkg.sv
// Shared definitions for the DLX pipeline hazard/stall controller.
// Contents:
//   REG_IDX_W     - register-index width
//   REG_ZERO      - index of the hard-wired zero register
//   pipe_state_t  - controller FSM states (run, load-use stall, memory wait)
package dlx_pkg;

  localparam int unsigned REG_IDX_W = 5;
  localparam logic [REG_IDX_W-1:0] REG_ZERO = 5'd0;

  typedef enum logic [1:0] {
    StRun     = 2'd0,
    StLuStall = 2'd1,
    StMemWait = 2'd2
  } pipe_state_t;

endpackage

// File: rtl/dlx_hazard_cmp.sv
// Load-use hazard comparator (purely combinational).
// Ports:
//   Rs1, Rs2 - source registers of the instruction in ID
//   Rd       - destination register of the instruction in EX
//   load     - EX instruction is a load
//   hazard   - ID instruction needs the load result before it is available
module dlx_hazard_cmp
  import dlx_pkg::*;
(
  input  logic [REG_IDX_W-1:0] Rs1,
  input  logic [REG_IDX_W-1:0] Rs2,
  input  logic [REG_IDX_W-1:0] Rd,
  input  logic                 load,
  output logic                 hazard
);

  // Writes to r0 are discarded, so a load targeting r0 never creates a dependency.
  assign hazard = load && (Rd != REG_ZERO) && ((Rd == Rs1) || (Rd == Rs2));

endmodule

// File: rtl/dlx_pipe_ctrl.sv
// DLX pipeline control: resolves memory-wait, taken-branch and load-use events into
// per-stage stall / bubble / flush commands, with optional performance counters.
// Optional feature: define DLX_PERF_CNT_EN to build the saturating stall/flush counters;
// otherwise stall_cnt and flush_cnt are tied to zero.
// Parameters:
//   LU_STALL_CYCLES - load-use stall length in cycles (1..3)
//   CNT_W           - performance counter width
// Ports:
//   clk, reset                    - clock, asynchronous active-high reset
//   Rs1_ID, Rs2_ID                - sources of the ID instruction
//   Rd_EX, d_load_enable_EX       - EX destination and EX-is-load
//   pc_cmd_EX                     - branch/jump taken in EX
//   d_req_MEM, d_ready_MEM        - MEM data access pending / acknowledged
//   stall_IF, stall_ID, stall_EX  - hold pipeline registers
//   bubble_EX                     - load a NOP into ID/EX
//   flush_ID, flush_EX            - squash IF/ID and ID/EX
//   stall_cnt, flush_cnt          - performance counters
module dlx_pipe_ctrl
  import dlx_pkg::*;
#(
  parameter int unsigned LU_STALL_CYCLES = 1,
  parameter int unsigned CNT_W           = 32
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [REG_IDX_W-1:0] Rs1_ID,
  input  logic [REG_IDX_W-1:0] Rs2_ID,
  input  logic [REG_IDX_W-1:0] Rd_EX,
  input  logic                 d_load_enable_EX,
  input  logic                 pc_cmd_EX,
  input  logic                 d_req_MEM,
  input  logic                 d_ready_MEM,
  output logic                 stall_IF,
  output logic                 stall_ID,
  output logic                 stall_EX,
  output logic                 bubble_EX,
  output logic                 flush_ID,
  output logic                 flush_EX,
  output logic [CNT_W-1:0]     stall_cnt,
  output logic [CNT_W-1:0]     flush_cnt
);

  localparam int unsigned LU_W = 2;

  pipe_state_t     state_q, state_d;
  pipe_state_t     ret_q, ret_d;
  logic [LU_W-1:0] lu_cnt_q, lu_cnt_d;
  logic            mem_busy;
  logic            load_use;

  assign mem_busy = d_req_MEM & ~d_ready_MEM;

  dlx_hazard_cmp u_hazard_cmp (
    .Rs1    (Rs1_ID),
    .Rs2    (Rs2_ID),
    .Rd     (Rd_EX),
    .load   (d_load_enable_EX),
    .hazard (load_use)
  );

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= StRun;
      ret_q    <= StRun;
      lu_cnt_q <= '0;
    end else begin
      state_q  <= state_d;
      ret_q    <= ret_d;
      lu_cnt_q <= lu_cnt_d;
    end
  end

  // Next-state logic; priority mem_busy > pc_cmd_EX > load_use.
  always_comb begin
    state_d  = state_q;
    ret_d    = ret_q;
    lu_cnt_d = lu_cnt_q;
    unique case (state_q)
      StRun: begin
        if (mem_busy) begin
          state_d = StMemWait;
          ret_d   = StRun;
        end else if (pc_cmd_EX) begin
          // Taken branch flushes the dependent instruction, so no load-use stall.
          state_d = StRun;
        end else if (load_use && (LU_STALL_CYCLES > 1)) begin
          lu_cnt_d = LU_W'(LU_STALL_CYCLES - 1);
          state_d  = StLuStall;
        end
      end
      StLuStall: begin
        // EX holds a bubble here, so pc_cmd_EX cannot legitimately fire.
        if (mem_busy) begin
          state_d = StMemWait;
          ret_d   = StLuStall;
        end else begin
          lu_cnt_d = lu_cnt_q - LU_W'(1);
          if (lu_cnt_q == LU_W'(1)) state_d = StRun;
        end
      end
      StMemWait: begin
        if (!mem_busy) begin
          state_d = ret_q;
          ret_d   = StRun;
        end
      end
      default: state_d = StRun;
    endcase
  end

  // Output logic; gated by reset so a held reset silences the pipeline immediately.
  always_comb begin
    stall_IF  = 1'b0;
    stall_ID  = 1'b0;
    stall_EX  = 1'b0;
    bubble_EX = 1'b0;
    flush_ID  = 1'b0;
    flush_EX  = 1'b0;
    if (!reset) begin
      unique case (state_q)
        StRun: begin
          if (mem_busy) begin
            {stall_IF, stall_ID, stall_EX} = 3'b111;
          end else if (pc_cmd_EX) begin
            {flush_ID, flush_EX} = 2'b11;
          end else if (load_use) begin
            {stall_IF, stall_ID, bubble_EX} = 3'b111;
          end
        end
        StLuStall: begin
          if (mem_busy) begin
            {stall_IF, stall_ID, stall_EX} = 3'b111;
          end else begin
            {stall_IF, stall_ID, bubble_EX} = 3'b111;
          end
        end
        StMemWait: begin
          if (mem_busy) {stall_IF, stall_ID, stall_EX} = 3'b111;
        end
        default: ;
      endcase
    end
  end

`ifdef DLX_PERF_CNT_EN
  logic [CNT_W-1:0] stall_cnt_q, flush_cnt_q;

  // Saturating counters.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      if (stall_IF && (stall_cnt_q != '1)) stall_cnt_q <= stall_cnt_q + CNT_W'(1);
      if (flush_ID && (flush_cnt_q != '1)) flush_cnt_q <= flush_cnt_q + CNT_W'(1);
    end
  end

  assign stall_cnt = stall_cnt_q;
  assign flush_cnt = flush_cnt_q;
`else
  assign stall_cnt = '0;
  assign flush_cnt = '0;
`endif

endmodule

// File: tb/tb_dlx_pipe_ctrl.sv
// Directed bench for dlx_pipe_ctrl: one instance with LU_STALL_CYCLES=1 (4-bit counters,
// for saturation) and one with LU_STALL_CYCLES=3, both driven by the same inputs.
module tb_dlx_pipe_ctrl;

  localparam int CW1 = 4;
  localparam int CW3 = 8;

  // Output vector layout: {stall_IF, stall_ID, stall_EX, bubble_EX, flush_ID, flush_EX}
  localparam logic [5:0] NONE = 6'b000000;
  localparam logic [5:0] LU   = 6'b110100;
  localparam logic [5:0] MEM  = 6'b111000;
  localparam logic [5:0] FL   = 6'b000011;

  logic           clk = 1'b0;
  logic           reset;
  logic [4:0]     rs1, rs2, rd;
  logic           ld, pc, req, rdy;
  logic [5:0]     o1, o3;
  logic [CW1-1:0] sc1, fc1;
  logic [CW3-1:0] sc3, fc3;

  int checks   = 0;
  int failures = 0;
  // Expected counter model, stepped from the expected output vectors.
  int es1 = 0, ef1 = 0, es3 = 0, ef3 = 0;

  always #5 clk = ~clk;

  dlx_pipe_ctrl #(.LU_STALL_CYCLES(1), .CNT_W(CW1)) dut1 (
    .clk(clk), .reset(reset), .Rs1_ID(rs1), .Rs2_ID(rs2), .Rd_EX(rd),
    .d_load_enable_EX(ld), .pc_cmd_EX(pc), .d_req_MEM(req), .d_ready_MEM(rdy),
    .stall_IF(o1[5]), .stall_ID(o1[4]), .stall_EX(o1[3]), .bubble_EX(o1[2]),
    .flush_ID(o1[1]), .flush_EX(o1[0]), .stall_cnt(sc1), .flush_cnt(fc1)
  );

  dlx_pipe_ctrl #(.LU_STALL_CYCLES(3), .CNT_W(CW3)) dut3 (
    .clk(clk), .reset(reset), .Rs1_ID(rs1), .Rs2_ID(rs2), .Rd_EX(rd),
    .d_load_enable_EX(ld), .pc_cmd_EX(pc), .d_req_MEM(req), .d_ready_MEM(rdy),
    .stall_IF(o3[5]), .stall_ID(o3[4]), .stall_EX(o3[3]), .bubble_EX(o3[2]),
    .flush_ID(o3[1]), .flush_EX(o3[0]), .stall_cnt(sc3), .flush_cnt(fc3)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] cexp(input int v);
`ifdef DLX_PERF_CNT_EN
    return 32'(v);
`else
    return 32'(v - v);
`endif
  endfunction

  task automatic check_cnts(input string tag);
    check({tag, ".sc1"}, 32'(sc1), cexp(es1));
    check({tag, ".fc1"}, 32'(fc1), cexp(ef1));
    check({tag, ".sc3"}, 32'(sc3), cexp(es3));
    check({tag, ".fc3"}, 32'(fc3), cexp(ef3));
  endtask

  // Drive one cycle's inputs at negedge, compare outputs 1 ns later, then advance the
  // counter model by what this cycle should contribute at the next rising edge.
  task automatic step(input string tag, input logic [4:0] a, input logic [4:0] b,
                      input logic [4:0] d, input logic l, input logic p, input logic q,
                      input logic r, input logic [5:0] e1, input logic [5:0] e3);
    @(negedge clk);
    rs1 = a; rs2 = b; rd = d; ld = l; pc = p; req = q; rdy = r;
    #1;
    check({tag, ".o1"}, 32'(o1), 32'(e1));
    check({tag, ".o3"}, 32'(o3), 32'(e3));
    check_cnts(tag);
    if (e1[5] && es1 < (1 << CW1) - 1) es1++;
    if (e1[1] && ef1 < (1 << CW1) - 1) ef1++;
    if (e3[5] && es3 < (1 << CW3) - 1) es3++;
    if (e3[1] && ef3 < (1 << CW3) - 1) ef3++;
  endtask

  task automatic idle(input string tag, input logic [5:0] e1, input logic [5:0] e3);
    step(tag, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, e1, e3);
  endtask

  initial begin
    reset = 1'b1;
    rs1 = '0; rs2 = '0; rd = '0; ld = 1'b0; pc = 1'b0; req = 1'b0; rdy = 1'b0;
    #1;
    check("rst.o1", 32'(o1), 32'(NONE));
    check("rst.o3", 32'(o3), 32'(NONE));
    check_cnts("rst");
    @(negedge clk);
    reset = 1'b0;

    // Load-use via Rs1: 1-cycle stall on dut1, 3-cycle stall on dut3.
    step("lu1_c0", 5'd5, 5'd0, 5'd5, 1'b1, 1'b0, 1'b0, 1'b0, LU, LU);
    idle("lu1_c1", NONE, LU);
    idle("lu1_c2", NONE, LU);
    idle("lu1_c3", NONE, NONE);
    idle("lu1_c4", NONE, NONE);

    // Load into r0 never stalls.
    step("r0", 5'd0, 5'd0, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0, NONE, NONE);
    // Non-load with matching registers never stalls.
    step("noload", 5'd7, 5'd0, 5'd7, 1'b0, 1'b0, 1'b0, 1'b0, NONE, NONE);

    // Load-use via Rs2.
    step("lu2_c0", 5'd1, 5'd7, 5'd7, 1'b1, 1'b0, 1'b0, 1'b0, LU, LU);
    idle("lu2_c1", NONE, LU);
    idle("lu2_c2", NONE, LU);
    idle("lu2_c3", NONE, NONE);

    // Taken branch with simultaneous load-use: flush only, stay in RUN.
    step("br_c0", 5'd9, 5'd0, 5'd9, 1'b1, 1'b1, 1'b0, 1'b0, FL, FL);
    idle("br_c1", NONE, NONE);

    // Memory wait from RUN; branch and load-use are overridden / ignored.
    step("mw_c0", 5'd3, 5'd0, 5'd3, 1'b1, 1'b1, 1'b1, 1'b0, MEM, MEM);
    step("mw_c1", 5'd3, 5'd0, 5'd3, 1'b1, 1'b1, 1'b1, 1'b0, MEM, MEM);
    step("mw_c2", 5'd3, 5'd0, 5'd3, 1'b1, 1'b1, 1'b1, 1'b1, NONE, NONE);
    step("mw_c3", 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0, FL, FL);
    idle("mw_c4", NONE, NONE);

    // Memory wait interrupting the 3-cycle load-use stall; stall resumes afterwards.
    step("lum_a", 5'd4, 5'd0, 5'd4, 1'b1, 1'b0, 1'b0, 1'b0, LU, LU);
    for (int i = 0; i < 4; i++)
      step($sformatf("lum_b%0d", i), 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, MEM, MEM);
    idle("lum_f", NONE, NONE);
    idle("lum_g", NONE, LU);
    idle("lum_h", NONE, LU);
    idle("lum_i", NONE, NONE);

    // Long memory wait saturates dut1's 4-bit stall counter.
    for (int i = 0; i < 20; i++)
      step($sformatf("sat%0d", i), 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, MEM, MEM);
    idle("sat_end", NONE, NONE);
    idle("sat_chk", NONE, NONE);

    // Reset pulsed in the middle of MEM_WAIT with the memory still busy.
    step("rmw_c0", 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, MEM, MEM);
    step("rmw_c1", 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, MEM, MEM);
    reset = 1'b1;
    #1;
    es1 = 0; ef1 = 0; es3 = 0; ef3 = 0;
    check("rmw_async.o1", 32'(o1), 32'(NONE));
    check("rmw_async.o3", 32'(o3), 32'(NONE));
    check_cnts("rmw_async");
    @(negedge clk);
    req = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    // A branch is only honoured in RUN, so a flush proves the FSM came out in RUN.
    step("rmw_run", 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0, FL, FL);
    idle("rmw_end", NONE, NONE);
    idle("rmw_cnt", NONE, NONE);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/dlx_pipe_ctrl.md
DLX_PIPE_CTRL -- requirements
Module: dlx_pipe_ctrl

Interface
REQ-001 SHALL have parameter LU_STALL_CYCLES, default 1, range 1..3: load-use stall length in cycles.
REQ-002 SHALL have parameter CNT_W, default 32: performance counter width.
REQ-003 SHALL have port clk  in  1  single clock; all state updates on its rising edge.
REQ-004 SHALL have port reset  in  1  asynchronous, active-high reset.
REQ-005 SHALL have ports Rs1_ID, Rs2_ID  in  5 each  source registers of the instruction in ID.
REQ-006 SHALL have ports Rd_EX (in, 5) and d_load_enable_EX (in, 1): EX destination register, and EX instruction is a load.
REQ-007 SHALL have port pc_cmd_EX  in  1  branch or jump taken in EX.
REQ-008 SHALL have ports d_req_MEM (in, 1) and d_ready_MEM (in, 1): MEM-stage data access pending, and data memory acknowledge.
REQ-009 SHALL have ports stall_IF, stall_ID, stall_EX  out  1 each  hold the corresponding pipeline register.
REQ-010 SHALL have port bubble_EX  out  1  load a NOP into the ID/EX register.
REQ-011 SHALL have ports flush_ID, flush_EX  out  1 each  squash the IF/ID and ID/EX contents.
REQ-012 SHALL have ports stall_cnt, flush_cnt  out  CNT_W each  performance counters.

Function
REQ-013 SHALL implement FSM states RUN, LU_STALL and MEM_WAIT.
REQ-014 SHALL define mem_busy = d_req_MEM & ~d_ready_MEM.
REQ-015 SHALL define load_use = d_load_enable_EX & (Rd_EX != 0) & (Rd_EX == Rs1_ID | Rd_EX == Rs2_ID).
REQ-016 SHALL resolve events by priority mem_busy > pc_cmd_EX > load_use, evaluated combinationally in the current cycle.
REQ-017 In RUN with mem_busy, SHALL assert stall_IF, stall_ID and stall_EX in that cycle and enter MEM_WAIT.
REQ-018 In RUN with pc_cmd_EX and no mem_busy, SHALL assert flush_ID and flush_EX for exactly that cycle and remain in RUN.
REQ-019 A branch SHALL suppress a simultaneous load_use: no stall is asserted, because the dependent instruction is flushed.
REQ-020 In RUN with load_use only, SHALL assert stall_IF, stall_ID and bubble_EX in that cycle.
REQ-021 When LU_STALL_CYCLES > 1, the load_use case SHALL load lu_cnt = LU_STALL_CYCLES-1 and enter LU_STALL; otherwise it SHALL stay in RUN.
REQ-022 In LU_STALL, SHALL assert stall_IF, stall_ID and bubble_EX and decrement lu_cnt; it SHALL return to RUN in the cycle lu_cnt reaches 0.
REQ-023 In LU_STALL with mem_busy, SHALL assert all stalls, deassert bubble_EX, freeze lu_cnt, record return state LU_STALL and enter MEM_WAIT.
REQ-024 In MEM_WAIT, SHALL assert stall_IF, stall_ID and stall_EX while mem_busy holds.
REQ-025 In the first cycle MEM_WAIT sees ~mem_busy, SHALL deassert all stalls and go to the recorded return state (RUN or LU_STALL).
REQ-026 pc_cmd_EX and load_use SHALL be ignored while in MEM_WAIT.
REQ-027 In any state, flush and stall SHALL NOT be asserted for the same stage in the same cycle.
REQ-028 stall_cnt SHALL increment in every cycle with stall_IF asserted; flush_cnt SHALL increment in every cycle with flush_ID asserted.
REQ-029 Both counters SHALL saturate at 2^CNT_W-1 rather than wrap.

Reset
REQ-030 Reset SHALL force state RUN, lu_cnt 0, return state RUN and both counters 0, with all stall, bubble and flush outputs deasserted, independent of clk.
REQ-031 Reset asserted mid-stall SHALL abandon the stall immediately; the first post-reset cycle SHALL evaluate inputs from RUN.

Configuration
REQ-032 Macro DLX_PERF_CNT_EN SHALL gate the counter logic.
REQ-033 With DLX_PERF_CNT_EN defined, counters SHALL behave per REQ-028 and REQ-029.
REQ-034 Without DLX_PERF_CNT_EN, stall_cnt and flush_cnt SHALL remain as ports tied to 0, with no counter flops.

Structure
REQ-035 Package dlx_pkg SHALL hold the FSM state enum pipe_state_t, REG_ZERO (5'd0) and the register-index width constant.
REQ-036 The load_use comparator SHALL be a combinational sub-module dlx_hazard_cmp (inputs Rs1, Rs2, Rd, load; output hazard).

Verification
REQ-037 Bench SHALL cover: Rd_EX=5, d_load_enable_EX=1, Rs1_ID=5, LU_STALL_CYCLES=1 -> stall_IF, stall_ID and bubble_EX high for exactly 1 cycle; stall_cnt=1.
REQ-038 Bench SHALL cover: Rd_EX=0, load, Rs1_ID=0 -> no stall.
REQ-039 Bench SHALL cover: LU_STALL_CYCLES=3 with load_use -> stall for 3 consecutive cycles, then RUN.
REQ-040 Bench SHALL cover: pc_cmd_EX=1 with a simultaneous load_use -> flush_ID and flush_EX high for 1 cycle, no stall; flush_cnt=1.
REQ-041 Bench SHALL cover: d_req_MEM=1 with d_ready_MEM low for 4 cycles during LU_STALL (cycles=3) -> all stalls for 4 cycles, then the remaining LU_STALL cycles resume.
REQ-042 Bench SHALL cover: reset pulsed in the middle of MEM_WAIT -> all outputs 0 asynchronously, counters 0, RUN on release.
